uart_di_master: RTL and testbench



---
 rtl/uart_di_pkg.sv | 26 ++
 rtl/uart_di_master.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_di_master.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_di_pkg.sv
// Shared constants and FSM encoding for the UART-to-DI bridge initiator.
package uart_di_pkg;

    localparam logic [7:0] CMD_WRITE = 8'hC3;
    localparam logic [7:0] CMD_READ  = 8'hC5;
    localparam logic [7:0] RSP_ACK   = 8'hA5;
    localparam logic [7:0] RSP_NAK   = 8'h5A;

    // TERM[2] + REG[4] + LEN[4] following the command byte
    localparam int unsigned HDR_BYTES = 10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_WR_BYTE0,
        ST_WR_BYTE1,
        ST_WR_ISSUE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_TX0,
        ST_RD_TX1,
        ST_ACK,
        ST_NAK
    } state_e;

endpackage

// File: rtl/uart_di_master.sv
// Serial-to-DI bridge initiator: decodes command packets from the UART receiver,
// runs DI write/read transfers as master and returns data plus ACK/NAK over the transmitter.
module uart_di_master
    import uart_di_pkg::*;
#(
    parameter int unsigned DI_DATA_WIDTH  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned TIMEOUT_WIDTH  = 20
) (
    input  logic                     ifclk,
    input  logic                     resetb,
    input  logic [7:0]               rx_data,
    input  logic                     rx_re,
    input  logic                     rx_error,
    output logic [7:0]               tx_data,
    output logic                     tx_we,
    input  logic                     tx_busy,
    output logic [15:0]              di_term_addr,
    output logic [31:0]              di_reg_addr,
    output logic [31:0]              di_len,
    output logic                     di_write_mode,
    output logic                     di_write,
    output logic [DI_DATA_WIDTH-1:0] di_reg_datai,
    input  logic                     di_write_rdy,
    output logic                     di_read_mode,
    output logic                     di_read_req,
    output logic                     di_read,
    input  logic [DI_DATA_WIDTH-1:0] di_reg_datao,
    input  logic                     di_read_rdy,
    input  logic [15:0]              di_transfer_status
);

    state_e                   state_q;
    logic [3:0]               hdr_cnt_q;
    logic [71:0]              hdr_q;
    logic                     cmd_rd_q;
    logic [30:0]              words_q;
    logic [DI_DATA_WIDTH-1:0] word_q;
    logic [7:0]               hold_q;
    logic                     hold_v_q;
    logic [15:0]              status_q;
    logic [1:0]               rsp_idx_q;
    logic [TIMEOUT_WIDTH-1:0] tmo_q;

    logic [7:0]               tx_data_q;
    logic                     tx_we_q;
    logic [15:0]              term_q;
    logic [31:0]              reg_q;
    logic [31:0]              len_q;
    logic                     wr_mode_q;
    logic                     wr_q;
    logic [DI_DATA_WIDTH-1:0] datai_q;
    logic                     rd_mode_q;
    logic                     rd_req_q;
    logic                     rd_q;

    logic [79:0] hdr_full;
    logic [31:0] hdr_len;
    logic        tx_ok;
    logic        rx_state;
    logic        tmo_hit;
    logic [7:0]  rsp_byte;

    assign hdr_full = {rx_data, hdr_q};
    assign hdr_len  = hdr_full[79:48];
    // A strobe issued last cycle blocks this one, covering a late-rising tx_busy.
    assign tx_ok    = !tx_busy && !tx_we_q;
    assign rx_state = state_q inside {ST_HDR, ST_WR_BYTE0, ST_WR_BYTE1};
    assign tmo_hit  = rx_state && !rx_re &&
                      (tmo_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_comb begin
        rsp_byte = 8'hFF;
        case (rsp_idx_q)
            2'd0:    rsp_byte = (state_q == ST_ACK) ? RSP_ACK : RSP_NAK;
            2'd1:    if (state_q == ST_ACK) rsp_byte = status_q[7:0];
            default: if (state_q == ST_ACK) rsp_byte = status_q[15:8];
        endcase
    end

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= ST_IDLE;
            hdr_cnt_q <= '0;
            hdr_q     <= '0;
            cmd_rd_q  <= 1'b0;
            words_q   <= '0;
            word_q    <= '0;
            hold_q    <= '0;
            hold_v_q  <= 1'b0;
            status_q  <= '0;
            rsp_idx_q <= '0;
            tmo_q     <= '0;
            tx_data_q <= '0;
            tx_we_q   <= 1'b0;
            term_q    <= '0;
            reg_q     <= '0;
            len_q     <= '0;
            wr_mode_q <= 1'b0;
            wr_q      <= 1'b0;
            datai_q   <= '0;
            rd_mode_q <= 1'b0;
            rd_req_q  <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            tx_we_q  <= 1'b0;
            wr_q     <= 1'b0;
            rd_req_q <= 1'b0;
            rd_q     <= 1'b0;

            if (!rx_state || rx_re) tmo_q <= '0;
            else                    tmo_q <= tmo_q + 1'b1;

            if (tmo_hit) begin
                state_q   <= ST_IDLE;
                wr_mode_q <= 1'b0;
                rd_mode_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_re && !rx_error && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
                            cmd_rd_q  <= (rx_data == CMD_READ);
                            hdr_cnt_q <= '0;
                            state_q   <= ST_HDR;
                        end
                    end
                    ST_HDR: begin
                        if (rx_re && rx_error) begin
                            state_q <= ST_NAK;
                        end else if (rx_re) begin
                            hdr_q     <= hdr_full[79:8];
                            hdr_cnt_q <= hdr_cnt_q + 4'd1;
                            if (hdr_cnt_q == 4'(HDR_BYTES - 1)) begin
                                if (hdr_len == '0 || hdr_len[0]) begin
                                    state_q <= ST_NAK;
                                end else begin
                                    term_q   <= hdr_full[15:0];
                                    reg_q    <= hdr_full[47:16];
                                    len_q    <= hdr_len;
                                    words_q  <= hdr_len[31:1];
                                    hold_v_q <= 1'b0;
                                    if (cmd_rd_q) begin
                                        rd_mode_q <= 1'b1;
                                        state_q   <= ST_RD_REQ;
                                    end else begin
                                        wr_mode_q <= 1'b1;
                                        state_q   <= ST_WR_BYTE0;
                                    end
                                end
                            end
                        end
                    end
                    ST_WR_BYTE0, ST_WR_BYTE1: begin
                        if (rx_re && rx_error) begin
                            wr_mode_q <= 1'b0;
                            state_q   <= ST_NAK;
                        end else if (rx_re && state_q == ST_WR_BYTE0) begin
                            word_q[7:0] <= rx_data;
                            state_q     <= ST_WR_BYTE1;
                        end else if (rx_re) begin
                            word_q[15:8] <= rx_data;
                            state_q      <= ST_WR_ISSUE;
                        end
                    end
                    ST_WR_ISSUE: begin
                        // The last word's strobe is followed by one cycle so it lands inside the mode window.
                        if (words_q == '0) begin
                            status_q  <= di_transfer_status;
                            wr_mode_q <= 1'b0;
                            state_q   <= ST_ACK;
                        end else if (rx_re && (rx_error || hold_v_q)) begin
                            wr_mode_q <= 1'b0;
                            state_q   <= ST_NAK;
                        end else if (di_write_rdy) begin
                            wr_q    <= 1'b1;
                            datai_q <= word_q;
                            words_q <= words_q - 31'd1;
                            if (words_q == 31'd1) begin
                                state_q <= ST_WR_ISSUE;
                            end else if (rx_re) begin
                                word_q[7:0] <= rx_data;
                                state_q     <= ST_WR_BYTE1;
                            end else if (hold_v_q) begin
                                word_q[7:0] <= hold_q;
                                hold_v_q    <= 1'b0;
                                state_q     <= ST_WR_BYTE1;
                            end else begin
                                state_q <= ST_WR_BYTE0;
                            end
                        end else if (rx_re) begin
                            hold_q   <= rx_data;
                            hold_v_q <= 1'b1;
                        end
                    end
                    ST_RD_REQ: begin
                        rd_req_q <= 1'b1;
                        state_q  <= ST_RD_WAIT;
                    end
                    ST_RD_WAIT: begin
                        if (di_read_rdy) begin
                            rd_q    <= 1'b1;
                            word_q  <= di_reg_datao;
                            state_q <= ST_RD_TX0;
                        end
                    end
                    ST_RD_TX0: begin
                        if (tx_ok) begin
                            tx_we_q   <= 1'b1;
                            tx_data_q <= word_q[7:0];
                            state_q   <= ST_RD_TX1;
                        end
                    end
                    ST_RD_TX1: begin
                        if (tx_ok) begin
                            tx_we_q   <= 1'b1;
                            tx_data_q <= word_q[15:8];
                            words_q   <= words_q - 31'd1;
                            if (words_q == 31'd1) begin
                                status_q  <= di_transfer_status;
                                rd_mode_q <= 1'b0;
                                state_q   <= ST_ACK;
                            end else begin
                                state_q <= ST_RD_REQ;
                            end
                        end
                    end
                    ST_ACK, ST_NAK: begin
                        if (tx_ok) begin
                            tx_we_q   <= 1'b1;
                            tx_data_q <= rsp_byte;
                            if (rsp_idx_q == 2'd2) begin
                                rsp_idx_q <= '0;
                                state_q   <= ST_IDLE;
                            end else begin
                                rsp_idx_q <= rsp_idx_q + 2'd1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_we         = tx_we_q;
    assign di_term_addr  = term_q;
    assign di_reg_addr   = reg_q;
    assign di_len        = len_q;
    assign di_write_mode = wr_mode_q;
    assign di_write      = wr_q;
    assign di_reg_datai  = datai_q;
    assign di_read_mode  = rd_mode_q;
    assign di_read_req   = rd_req_q;
    assign di_read       = rd_q;

endmodule

// File: tb/tb_uart_di_master.sv
// Directed bench for uart_di_master: scripted packets against a UART transmitter
// model and a DI terminal model, with hand-computed expected bytes and words.
module tb_uart_di_master;
    import uart_di_pkg::*;

    typedef logic [7:0]  bytes_t [$];
    typedef logic [15:0] words_t [$];

    logic        ifclk = 1'b0;
    logic        resetb = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_re = 1'b0;
    logic        rx_error = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_we;
    logic        tx_busy = 1'b0;
    logic [15:0] di_term_addr;
    logic [31:0] di_reg_addr;
    logic [31:0] di_len;
    logic        di_write_mode;
    logic        di_write;
    logic [15:0] di_reg_datai;
    logic        di_write_rdy = 1'b0;
    logic        di_read_mode;
    logic        di_read_req;
    logic        di_read;
    logic [15:0] di_reg_datao = 16'h0000;
    logic        di_read_rdy = 1'b0;
    logic [15:0] di_transfer_status = 16'h0000;

    int n_total = 0;
    int n_bad   = 0;

    // terminal/transmitter model state and observation logs
    logic [7:0]  txq [$];
    logic [15:0] wq [$];
    logic [15:0] rd_words [0:3];
    int busy_len = 0, busy_cnt = 0;
    int rd_lat = 3, rd_delay = 0, rd_idx = 0;
    int busy_viol = 0, same_viol = 0, nomode_viol = 0;
    int n_rd = 0, n_strobe = 0, n_mode = 0;
    int tx_base = 0, w_base = 0;

    always #5 ifclk = ~ifclk;

    uart_di_master #(
        .DI_DATA_WIDTH (16),
        .TIMEOUT_CYCLES(100),
        .TIMEOUT_WIDTH (20)
    ) dut (
        .ifclk             (ifclk),
        .resetb            (resetb),
        .rx_data           (rx_data),
        .rx_re             (rx_re),
        .rx_error          (rx_error),
        .tx_data           (tx_data),
        .tx_we             (tx_we),
        .tx_busy           (tx_busy),
        .di_term_addr      (di_term_addr),
        .di_reg_addr       (di_reg_addr),
        .di_len            (di_len),
        .di_write_mode     (di_write_mode),
        .di_write          (di_write),
        .di_reg_datai      (di_reg_datai),
        .di_write_rdy      (di_write_rdy),
        .di_read_mode      (di_read_mode),
        .di_read_req       (di_read_req),
        .di_read           (di_read),
        .di_reg_datao      (di_reg_datao),
        .di_read_rdy       (di_read_rdy),
        .di_transfer_status(di_transfer_status)
    );

    always @(negedge ifclk) begin
        if (tx_we) begin
            if (tx_busy) busy_viol++;
            txq.push_back(tx_data);
            if (busy_len != 0) begin
                tx_busy  = 1'b1;
                busy_cnt = busy_len;
            end
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end

        if (di_write) wq.push_back(di_reg_datai);
        if (di_write || di_read || di_read_req) n_strobe++;
        if ((di_write && !di_write_mode) || ((di_read || di_read_req) && !di_read_mode)) nomode_viol++;
        if (di_write_mode || di_read_mode) n_mode++;

        if (!di_read_mode) begin
            di_read_rdy = 1'b0;
            rd_idx      = 0;
            rd_delay    = 0;
        end else begin
            if (di_read) begin
                di_read_rdy = 1'b0;
                rd_idx++;
                n_rd++;
            end
            if (di_read_req) begin
                if (di_read) same_viol++;
                rd_delay = rd_lat;
            end else if (rd_delay > 0) begin
                rd_delay--;
                if (rd_delay == 0) begin
                    di_read_rdy  = 1'b1;
                    di_reg_datao = rd_words[rd_idx % 4];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err, input int gap);
        @(negedge ifclk);
        rx_data  = b;
        rx_re    = 1'b1;
        rx_error = err;
        @(negedge ifclk);
        rx_re    = 1'b0;
        rx_error = 1'b0;
        repeat (gap) @(negedge ifclk);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] term,
                            input logic [31:0] regad, input logic [31:0] len, input int gap);
        send_byte(cmd, 1'b0, gap);
        for (int i = 0; i < 2; i++) send_byte(term[8*i +: 8], 1'b0, gap);
        for (int i = 0; i < 4; i++) send_byte(regad[8*i +: 8], 1'b0, gap);
        for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], 1'b0, gap);
    endtask

    task automatic expect_tx(input string tag, input bytes_t exp);
        int k = 0;
        while (txq.size() < tx_base + exp.size() && k < 3000) begin
            @(negedge ifclk);
            k++;
        end
        repeat (4) @(negedge ifclk);
        check({tag, "_cnt"}, txq.size() - tx_base, exp.size());
        for (int i = 0; i < exp.size(); i++)
            if (tx_base + i < txq.size()) check(tag, txq[tx_base + i], exp[i]);
        tx_base = txq.size();
    endtask

    task automatic expect_wr(input string tag, input words_t exp);
        check({tag, "_cnt"}, wq.size() - w_base, exp.size());
        for (int i = 0; i < exp.size(); i++)
            if (w_base + i < wq.size()) check(tag, wq[w_base + i], exp[i]);
        w_base = wq.size();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, m0, r0, b0, t0;
        repeat (3) @(negedge ifclk);
        check("rst_addr", {di_term_addr, di_reg_addr}, '0);
        check("rst_len", di_len, '0);
        check("rst_ctl", {tx_data, tx_we, di_write_mode, di_write, di_read_mode,
                          di_read_req, di_read, di_reg_datai}, '0);
        resetb = 1'b1;
        repeat (2) @(negedge ifclk);

        // basic write, len 4
        di_write_rdy = 1'b1;
        send_hdr(CMD_WRITE, 16'h1234, 32'h12345678, 32'd4, 0);
        check("wr_term", di_term_addr, 16'h1234);
        check("wr_reg", di_reg_addr, 32'h12345678);
        check("wr_len", di_len, 32'd4);
        check("wr_mode_on", di_write_mode, 1'b1);
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'hBB, 1'b0, 0);
        send_byte(8'hCC, 1'b0, 0);
        send_byte(8'hDD, 1'b0, 0);
        expect_tx("wr_rsp", '{8'hA5, 8'h00, 8'h00});
        expect_wr("wr_data", '{16'hBBAA, 16'hDDCC});
        check("wr_mode_off", di_write_mode, 1'b0);

        // read, len 6, with slow terminal and busy transmitter
        busy_len = 10;
        rd_lat   = 3;
        rd_words = '{16'h0102, 16'h0304, 16'h0506, 16'h0000};
        r0 = n_rd;
        b0 = busy_viol;
        send_hdr(CMD_READ, 16'h0007, 32'h00000010, 32'd6, 0);
        check("rd_mode_on", di_read_mode, 1'b1);
        expect_tx("rd_rsp", '{8'h02, 8'h01, 8'h04, 8'h03, 8'h06, 8'h05, 8'hA5, 8'h00, 8'h00});
        check("rd_reads", n_rd - r0, 3);
        check("rd_busy_viol", busy_viol - b0, 0);
        check("rd_same_cycle", same_viol, 0);
        check("rd_mode_off", di_read_mode, 1'b0);
        busy_len = 0;
        repeat (15) @(negedge ifclk);

        // bad lengths: odd and zero
        s0 = n_strobe;
        m0 = n_mode;
        send_hdr(CMD_WRITE, 16'h0001, 32'h00000002, 32'd3, 0);
        expect_tx("len3_rsp", '{8'h5A, 8'hFF, 8'hFF});
        send_hdr(CMD_READ, 16'h0001, 32'h00000002, 32'd0, 0);
        expect_tx("len0_rsp", '{8'h5A, 8'hFF, 8'hFF});
        check("badlen_strobes", n_strobe - s0, 0);
        check("badlen_mode", n_mode - m0, 0);

        // receive error on second data byte, then a clean packet
        send_hdr(CMD_WRITE, 16'h1234, 32'h12345678, 32'd4, 0);
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'hBB, 1'b1, 0);
        check("rxerr_mode", di_write_mode, 1'b0);
        expect_tx("rxerr_rsp", '{8'h5A, 8'hFF, 8'hFF});
        expect_wr("rxerr_wr", '{});
        send_hdr(CMD_WRITE, 16'h1234, 32'h12345678, 32'd2, 0);
        send_byte(8'h11, 1'b0, 0);
        send_byte(8'h22, 1'b0, 0);
        expect_tx("rxerr_next_rsp", '{8'hA5, 8'h00, 8'h00});
        expect_wr("rxerr_next_wr", '{16'h2211});

        // timeout after 5 bytes, then recovery
        t0 = txq.size();
        send_byte(CMD_WRITE, 1'b0, 0);
        send_byte(8'h34, 1'b0, 0);
        send_byte(8'h12, 1'b0, 0);
        send_byte(8'h78, 1'b0, 0);
        send_byte(8'h56, 1'b0, 0);
        repeat (110) @(negedge ifclk);
        check("tmo_silent", txq.size() - t0, 0);
        send_hdr(CMD_WRITE, 16'h4321, 32'h87654321, 32'd2, 0);
        check("tmo_next_term", di_term_addr, 16'h4321);
        send_byte(8'h33, 1'b0, 0);
        send_byte(8'h44, 1'b0, 0);
        expect_tx("tmo_next_rsp", '{8'hA5, 8'h00, 8'h00});
        expect_wr("tmo_next_wr", '{16'h4433});

        // gaps just below the timeout still decode
        send_hdr(CMD_WRITE, 16'hABCD, 32'hCAFEF00D, 32'd2, 95);
        check("gap_reg", di_reg_addr, 32'hCAFEF00D);
        send_byte(8'h55, 1'b0, 95);
        send_byte(8'h66, 1'b0, 0);
        expect_tx("gap_rsp", '{8'hA5, 8'h00, 8'h00});
        expect_wr("gap_wr", '{16'h6655});

        // terminal status passes through to the ACK
        di_transfer_status = 16'hFFFE;
        rd_words[0] = 16'hBEEF;
        send_hdr(CMD_READ, 16'h0002, 32'h00000040, 32'd2, 0);
        expect_tx("status_rsp", '{8'hEF, 8'hBE, 8'hA5, 8'hFE, 8'hFF});
        di_transfer_status = 16'h0000;

        // reset while a read waits on the terminal
        rd_lat = 60;
        send_hdr(CMD_READ, 16'h0009, 32'h00000020, 32'd4, 0);
        check("rst_rd_mode_on", di_read_mode, 1'b1);
        repeat (5) @(negedge ifclk);
        t0 = txq.size();
        resetb = 1'b0;
        #1;
        check("rst_mid_addr", {di_term_addr, di_reg_addr}, '0);
        check("rst_mid_len", di_len, '0);
        check("rst_mid_ctl", {tx_we, di_write_mode, di_write, di_read_mode, di_read_req, di_read}, '0);
        @(negedge ifclk);
        resetb = 1'b1;
        repeat (80) @(negedge ifclk);
        check("rst_no_ack", txq.size() - t0, 0);
        check("strobe_outside_mode", nomode_viol, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
